// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: single-port RAM shared by a host port and round-robin arbitrated gpu channels; define DMEM_STALL_STATS_EN to enable stall_count
module dmem_port_arbiter #(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8,
  parameter int NUM_CHANNELS = 4,
  parameter int STAT_BITS    = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CHANNELS-1:0]           read_valid,
  input  logic [NUM_CHANNELS*ADDR_BITS-1:0] read_address,
  output logic [NUM_CHANNELS-1:0]           read_ready,
  output logic [NUM_CHANNELS*DATA_BITS-1:0] read_data,
  input  logic [NUM_CHANNELS-1:0]           write_valid,
  input  logic [NUM_CHANNELS*ADDR_BITS-1:0] write_address,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0] write_data,
  output logic [NUM_CHANNELS-1:0]           write_ready,
  input  logic                              host_en,
  input  logic                              host_we,
  input  logic [ADDR_BITS-1:0]              host_addr,
  input  logic [DATA_BITS-1:0]              host_wdata,
  output logic [DATA_BITS-1:0]              host_rdata,
  output logic [STAT_BITS-1:0]              stall_count
);
  localparam int PW    = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1;
  localparam int DEPTH = 2 ** ADDR_BITS;
  logic [DATA_BITS-1:0]              mem_q [DEPTH];
  logic [NUM_CHANNELS-1:0]           rd_rdy_q, rd_rdy_d, wr_rdy_q, wr_rdy_d;
  logic [NUM_CHANNELS-1:0]           rd_elig, wr_elig, elig;
  logic [NUM_CHANNELS*DATA_BITS-1:0] rd_data_q, rd_data_d;
  logic [DATA_BITS-1:0]              host_rdata_q, host_rdata_d;
  logic [PW-1:0]                     ptr_q, ptr_d, gnt_idx;
  logic                              gnt_vld, gnt_wr, mem_we;
  logic [ADDR_BITS-1:0]              mem_waddr, gnt_raddr;
  logic [DATA_BITS-1:0]              mem_wdata;

  assign rd_elig = read_valid & ~rd_rdy_q;
  assign wr_elig = write_valid & ~wr_rdy_q;
  assign elig    = rd_elig | wr_elig;
  assign gnt_vld = ~host_en & |elig;
  assign gnt_wr  = wr_elig[gnt_idx];

  // round-robin search: scan downwards so the lowest offset from the pointer is assigned last and wins
  always_comb begin
    gnt_idx = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--)
      if (elig[(int'(ptr_q) + i) % NUM_CHANNELS]) gnt_idx = PW'((int'(ptr_q) + i) % NUM_CHANNELS);
  end

  assign ptr_d     = gnt_vld ? (int'(gnt_idx) == NUM_CHANNELS - 1 ? '0 : gnt_idx + 1'b1) : ptr_q;
  assign mem_we    = host_en ? host_we : gnt_vld & gnt_wr;
  assign mem_waddr = host_en ? host_addr : write_address[gnt_idx*ADDR_BITS +: ADDR_BITS];
  assign mem_wdata = host_en ? host_wdata : write_data[gnt_idx*DATA_BITS +: DATA_BITS];
  assign gnt_raddr = read_address[gnt_idx*ADDR_BITS +: ADDR_BITS];

  // completion pulses and read results for the granted channel, plus host readback
  always_comb begin
    rd_rdy_d     = '0;
    wr_rdy_d     = '0;
    rd_data_d    = rd_data_q;
    host_rdata_d = (host_en & ~host_we) ? mem_q[host_addr] : host_rdata_q;
    if (gnt_vld & gnt_wr) wr_rdy_d[gnt_idx] = 1'b1;
    if (gnt_vld & ~gnt_wr) begin
      rd_rdy_d[gnt_idx] = 1'b1;
      rd_data_d[gnt_idx*DATA_BITS +: DATA_BITS] = mem_q[gnt_raddr];
    end
  end

  // RAM array is never cleared so preloaded contents survive reset
  always_ff @(posedge clk)
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;

  // control and output registers
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rd_rdy_q     <= '0;
      wr_rdy_q     <= '0;
      rd_data_q    <= '0;
      host_rdata_q <= '0;
      ptr_q        <= '0;
    end else begin
      rd_rdy_q     <= rd_rdy_d;
      wr_rdy_q     <= wr_rdy_d;
      rd_data_q    <= rd_data_d;
      host_rdata_q <= host_rdata_d;
      ptr_q        <= ptr_d;
    end

  assign read_ready  = rd_rdy_q;
  assign write_ready = wr_rdy_q;
  assign read_data   = rd_data_q;
  assign host_rdata  = host_rdata_q;

`ifdef DMEM_STALL_STATS_EN
  logic [STAT_BITS-1:0] stall_q;
  logic                 stall;
  assign stall = host_en ? |elig : |(elig & ~(NUM_CHANNELS'(1) << gnt_idx));
  // saturating count of cycles where some eligible channel was left waiting
  always_ff @(posedge clk or negedge reset)
    if (!reset) stall_q <= '0;
    else if (stall & ~&stall_q) stall_q <= stall_q + 1'b1;
  assign stall_count = stall_q;
`else
  assign stall_count = '0;
`endif
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed vectors for host port, arbitration, ordering and reset
module tb_dmem_port_arbiter;
  logic        clk = 0, reset = 0;
  logic [3:0]  read_valid = '0, write_valid = '0, read_ready, write_ready;
  logic [31:0] read_address = '0, write_address = '0, write_data = '0, read_data;
  logic        host_en = 0, host_we = 0;
  logic [7:0]  host_addr = '0, host_wdata = '0, host_rdata;
  logic [15:0] stall_count;
  int nvec = 0, nerr = 0;

  dmem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .read_valid(read_valid), .read_address(read_address), .read_ready(read_ready), .read_data(read_data),
    .write_valid(write_valid), .write_address(write_address), .write_data(write_data), .write_ready(write_ready),
    .host_en(host_en), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    step();
    step();
    nvec++; if (read_ready !== 4'b0) begin nerr++; $display("FAIL reset_rr got %b exp 0000", read_ready); end
    nvec++; if (write_ready !== 4'b0) begin nerr++; $display("FAIL reset_wr got %b exp 0000", write_ready); end
    nvec++; if (read_data !== 32'h0) begin nerr++; $display("FAIL reset_rd got %h exp 0", read_data); end
    nvec++; if (host_rdata !== 8'h0) begin nerr++; $display("FAIL reset_hr got %h exp 0", host_rdata); end
    nvec++; if (stall_count !== 16'h0) begin nerr++; $display("FAIL reset_stall got %0d exp 0", stall_count); end
    reset = 1;
    step();
  endtask

  task automatic test_preload();
    host_en = 1; host_we = 1;
    for (int i = 0; i < 4; i++) begin
      host_addr = 8'(i); host_wdata = 8'(i + 1);
      step();
    end
    host_we = 0; host_addr = 8'd2;
    step();
    host_en = 0;
    nvec++; if (host_rdata !== 8'd3) begin nerr++; $display("FAIL host_read got %0d exp 3", host_rdata); end
    nvec++; if (read_ready !== 4'b0) begin nerr++; $display("FAIL host_no_grant got %b exp 0000", read_ready); end
  endtask

  task automatic test_contention();
    read_address = {8'd3, 8'd2, 8'd1, 8'd0};
    read_valid = 4'hF;
    for (int k = 0; k < 4; k++) begin
      step();
      nvec++; if (read_ready !== 4'(1 << k)) begin nerr++; $display("FAIL cont_rdy%0d got %b exp %b", k, read_ready, 4'(1 << k)); end
      nvec++; if (read_data[k*8 +: 8] !== 8'(k + 1)) begin nerr++; $display("FAIL cont_data%0d got %0d exp %0d", k, read_data[k*8 +: 8], k + 1); end
      read_valid[k] = 0;
    end
    step();
    nvec++; if (read_ready !== 4'b0) begin nerr++; $display("FAIL cont_idle got %b exp 0000", read_ready); end
`ifndef DMEM_STALL_STATS_EN
    nvec++; if (stall_count !== 16'h0) begin nerr++; $display("FAIL stall_off got %0d exp 0", stall_count); end
`endif
  endtask

  task automatic test_single_read();
    read_address[7:0] = 8'd1; read_valid[0] = 1;
    step();
    nvec++; if (read_ready !== 4'b0001) begin nerr++; $display("FAIL single_rdy got %b exp 0001", read_ready); end
    nvec++; if (read_data[7:0] !== 8'd2) begin nerr++; $display("FAIL single_data got %0d exp 2", read_data[7:0]); end
    read_valid = '0;
    step();
    nvec++; if (read_ready !== 4'b0) begin nerr++; $display("FAIL single_once got %b exp 0000", read_ready); end
    nvec++; if (read_data[7:0] !== 8'd2) begin nerr++; $display("FAIL single_hold got %0d exp 2", read_data[7:0]); end
  endtask

  task automatic test_rr_wrap();
    read_address[23:16] = 8'd3; read_valid[2] = 1;
    step();
    nvec++; if (read_ready !== 4'b0100) begin nerr++; $display("FAIL rr_ch2 got %b exp 0100", read_ready); end
    read_valid = 4'b1001; read_address[7:0] = 8'd0; read_address[31:24] = 8'd1;
    step();
    nvec++; if (read_ready !== 4'b1000) begin nerr++; $display("FAIL rr_ch3 got %b exp 1000", read_ready); end
    nvec++; if (read_data[31:24] !== 8'd2) begin nerr++; $display("FAIL rr_ch3_data got %0d exp 2", read_data[31:24]); end
    read_valid[3] = 0;
    step();
    nvec++; if (read_ready !== 4'b0001) begin nerr++; $display("FAIL rr_ch0 got %b exp 0001", read_ready); end
    nvec++; if (read_data[7:0] !== 8'd1) begin nerr++; $display("FAIL rr_ch0_data got %0d exp 1", read_data[7:0]); end
    read_valid = '0;
    step();
  endtask

  task automatic test_write_read();
    write_address[15:8] = 8'd8; write_data[15:8] = 8'd7; write_valid[1] = 1;
    read_address[15:8] = 8'd8; read_valid[1] = 1;
    step();
    nvec++; if (write_ready !== 4'b0010) begin nerr++; $display("FAIL wr_first got %b exp 0010", write_ready); end
    nvec++; if (read_ready !== 4'b0) begin nerr++; $display("FAIL rd_held got %b exp 0000", read_ready); end
    write_valid = '0;
    step();
    nvec++; if (read_ready !== 4'b0010) begin nerr++; $display("FAIL rd_second got %b exp 0010", read_ready); end
    nvec++; if (read_data[15:8] !== 8'd7) begin nerr++; $display("FAIL raw_data got %0d exp 7", read_data[15:8]); end
    nvec++; if (write_ready !== 4'b0) begin nerr++; $display("FAIL wr_once got %b exp 0000", write_ready); end
    read_valid = '0;
    step();
  endtask

  task automatic test_host_delay();
    read_address[7:0] = 8'd3; read_valid[0] = 1;
    host_en = 1; host_we = 0; host_addr = 8'd0;
    step();
    nvec++; if (read_ready !== 4'b0) begin nerr++; $display("FAIL hd_wait1 got %b exp 0000", read_ready); end
    nvec++; if (host_rdata !== 8'd1) begin nerr++; $display("FAIL hd_hostrd got %0d exp 1", host_rdata); end
    step();
    nvec++; if (read_ready !== 4'b0) begin nerr++; $display("FAIL hd_wait2 got %b exp 0000", read_ready); end
    host_en = 0;
    step();
    nvec++; if (read_ready !== 4'b0001) begin nerr++; $display("FAIL hd_served got %b exp 0001", read_ready); end
    nvec++; if (read_data[7:0] !== 8'd4) begin nerr++; $display("FAIL hd_data got %0d exp 4", read_data[7:0]); end
    read_valid = '0;
    step();
  endtask

  task automatic test_host_collision();
    host_en = 1; host_we = 1; host_addr = 8'd5; host_wdata = 8'd9;
    read_address[23:16] = 8'd5; read_valid[2] = 1;
    step();
    nvec++; if (read_ready !== 4'b0) begin nerr++; $display("FAIL hc_wait got %b exp 0000", read_ready); end
    host_en = 0; host_we = 0;
    step();
    nvec++; if (read_ready !== 4'b0100) begin nerr++; $display("FAIL hc_served got %b exp 0100", read_ready); end
    nvec++; if (read_data[23:16] !== 8'd9) begin nerr++; $display("FAIL hc_data got %0d exp 9", read_data[23:16]); end
    read_valid = '0;
    step();
  endtask

  task automatic test_reset_mid();
    read_address[23:0] = {8'd2, 8'd1, 8'd0};
    read_valid = 4'b0111;
    step();
    nvec++; if (read_ready !== 4'b0001) begin nerr++; $display("FAIL rm_pre got %b exp 0001", read_ready); end
    #2 reset = 0;
    #1;
    nvec++; if (read_ready !== 4'b0) begin nerr++; $display("FAIL rm_async_rdy got %b exp 0000", read_ready); end
    nvec++; if (read_data !== 32'h0) begin nerr++; $display("FAIL rm_async_data got %h exp 0", read_data); end
    @(negedge clk);
    reset = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      nvec++; if (read_ready !== 4'(1 << k)) begin nerr++; $display("FAIL rm_rdy%0d got %b exp %b", k, read_ready, 4'(1 << k)); end
      nvec++; if (read_data[k*8 +: 8] !== 8'(k + 1)) begin nerr++; $display("FAIL rm_data%0d got %0d exp %0d", k, read_data[k*8 +: 8], k + 1); end
      read_valid[k] = 0;
    end
    step();
    nvec++; if (read_ready !== 4'b0) begin nerr++; $display("FAIL rm_idle got %b exp 0000", read_ready); end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_contention();
    test_single_read();
    test_rr_wrap();
    test_write_read();
    test_host_delay();
    test_host_collision();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
